// File: rtl/ksln_response_compactor.sv
// 16-bit MISR response compactor that signs num_patterns 4-bit response words and compares the result against golden.
// Latency: each absorbed word shows up in signature one cycle later; done/pass go valid the cycle after the final word.
// Backpressure: resp_ready is high only in RUN, so words offered in IDLE or DONE are dropped, and resp_valid may stall indefinitely.
module ksln_response_compactor #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic [7:0]  num_patterns,
    input  logic [15:0] golden,
    input  logic        resp_valid,
    input  logic [3:0]  resp,
    output logic        resp_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [7:0]  count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] golden_q;
    logic [7:0]  num_q;
    logic        fb;
    logic [15:0] sig_nxt;
    logic [7:0]  cnt_nxt;

    // MISR taps at bits 15, 14, 12 and 3; the response word folds into the low nibble.
    always_comb begin
        fb      = signature[15] ^ signature[14] ^ signature[12] ^ signature[3];
        sig_nxt = {signature[14:0], fb} ^ {12'b0, resp};
        cnt_nxt = count + 8'd1;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= IDLE;
            signature  <= SEED;
            count      <= 8'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b0;
            resp_ready <= 1'b0;
            golden_q   <= 16'd0;
            num_q      <= 8'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        signature <= SEED;
                        count     <= 8'd0;
                        golden_q  <= golden;
                        num_q     <= num_patterns;
                        if (num_patterns != 8'd0) begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            resp_ready <= 1'b1;
                            done       <= 1'b0;
                            pass       <= 1'b0;
                        end else begin
                            // Empty run: the seed itself is the final signature.
                            state      <= DONE;
                            busy       <= 1'b0;
                            resp_ready <= 1'b0;
                            done       <= 1'b1;
                            pass       <= (SEED == golden);
                        end
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        signature <= sig_nxt;
                        count     <= cnt_nxt;
                        if (cnt_nxt == num_q) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            resp_ready <= 1'b0;
                            done       <= 1'b1;
                            pass       <= (sig_nxt == golden_q);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    resp_ready <= 1'b0;
                    done       <= 1'b0;
                    pass       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ksln_response_compactor.md
KSLN_RESPONSE_COMPACTOR -- requirements
Module: ksln_response_compactor

Interface
REQ-001 Parameter SEED, default 16'hACE1, MISR initial value loaded on reset and on every accepted start.
REQ-002 CK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a compaction run.
REQ-005 num_patterns  input  8  number of responses to absorb; sampled when start is accepted.
REQ-006 golden  input  16  expected signature; sampled when start is accepted.
REQ-007 resp_valid  input  1  upstream response-word valid.
REQ-008 resp  input  4  response word {N223,N329,N370,N421}, bit 3 = N223, bit 0 = N421.
REQ-009 resp_ready  output  1  compactor accepts resp this cycle.
REQ-010 busy  output  1  run in progress.
REQ-011 done  output  1  run complete; signature and pass valid.
REQ-012 pass  output  1  final signature equals sampled golden.
REQ-013 signature  output  16  current MISR contents.
REQ-014 count  output  8  responses absorbed in the current run.

Function
REQ-015 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-016 A start is accepted in IDLE or DONE; start in RUN is ignored with no effect on any state.
REQ-017 On accepted start: signature<=SEED, count<=0, golden and num_patterns registered, done<=0, pass<=0; next state RUN if num_patterns!=0, else DONE.
REQ-018 When num_patterns==0, DONE is entered one cycle after start, with signature=SEED and pass=(SEED==golden).
REQ-019 resp_ready = 1 only in RUN; busy = 1 only in RUN; done = 1 only in DONE.
REQ-020 A response transfer occurs when resp_valid && resp_ready; no transfer occurs outside RUN, and resp is ignored then.
REQ-021 Per transfer: fb = sig[15]^sig[14]^sig[12]^sig[3]; sig <= {sig[14:0],fb} ^ {12'b0,resp}; count <= count+1.
REQ-022 Cycles in RUN without resp_valid hold signature and count unchanged; stalls of any length are allowed.
REQ-023 The transfer that makes count equal to num_patterns moves the FSM to DONE on the same edge; pass is computed from the post-update signature and registered on that edge.
REQ-024 No more than num_patterns transfers are absorbed per run; resp_ready is low from the first DONE cycle.
REQ-025 DONE holds signature, count, pass and done stable until RST or the next accepted start.
REQ-026 count does not wrap, because num_patterns<=255 bounds it.
REQ-027 Latency: signature reflects a transfer on the cycle after it; done/pass are valid the cycle after the final transfer.

Reset
REQ-028 While RST=1 at a clock edge: state<=IDLE, signature<=SEED, count<=0, done<=0, pass<=0, busy<=0, resp_ready<=0; registered golden/num_patterns<=0.
REQ-029 RST overrides start and resp_valid in the same cycle; an in-progress run is abandoned, and no partial pass/done is ever shown.
REQ-030 Outputs are deterministic in the first cycle after RST deasserts, with no dependence on pre-reset state.

Verification
REQ-031 Reset then idle: signature=16'hACE1, count=0, done=0, pass=0, resp_ready=0; resp_valid pulses in IDLE leave signature unchanged.
REQ-032 start, num_patterns=1, golden=16'h59CC, single resp=4'hF -> signature=16'h59CC, count=1, done=1, pass=1 next cycle.
REQ-033 start, num_patterns=1, golden=16'h59CC, resp=4'h0 -> signature=16'h59C3, done=1, pass=0.
REQ-034 start, num_patterns=0, golden=16'hACE1 -> DONE after one cycle, signature=16'hACE1, pass=1, resp_ready never high.
REQ-035 num_patterns=3 with resp_valid stalls between words, start pulsed mid-run, and an extra 4th valid word after DONE -> mid-run start ignored, count=3, 4th word not absorbed, signature matches the reference model.
REQ-036 RST asserted after 2 of 5 transfers -> next cycle is the IDLE reset state per REQ-028; a fresh start/run yields the correct signature.
